// File: rtl/microprocesador.sv
// Single-cycle 8-bit microprocessor: fixed 16-bit instruction ROM, four registers,
// 16-word data memory and Z/C flags. Register writes are exposed for observation.
module microprocesador #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic [PC_W-1:0]   pc_o,
    output logic              halted_o,
    output logic              wr_en_o,
    output logic [1:0]        wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQZ = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;

    logic [PC_W-1:0]   r_pc;
    logic              r_halted;
    logic              r_z;
    logic              r_c;
    logic [DATA_W-1:0] r_regs [4];
    logic [DATA_W-1:0] r_dmem [16];

    logic [15:0]       w_instr;
    logic [3:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic [7:0]        w_imm;
    logic [DATA_W-1:0] w_rd_val;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W:0]   w_ext;
    logic [DATA_W-1:0] w_result;
    logic              w_wr_en;
    logic              w_flag_upd;
    logic              w_c_upd;
    logic [PC_W-1:0]   w_pc_next;

    always_comb begin
        case (r_pc)
            PC_W'(0):  w_instr = 16'h1005;  // LDI  r0,5
            PC_W'(1):  w_instr = 16'h1403;  // LDI  r1,3
            PC_W'(2):  w_instr = 16'h2100;  // ADD  r0,r1
            PC_W'(3):  w_instr = 16'h9002;  // ST   r0,[2]
            PC_W'(4):  w_instr = 16'h8802;  // LD   r2,[2]
            PC_W'(5):  w_instr = 16'h3900;  // SUB  r2,r1
            PC_W'(6):  w_instr = 16'h1C03;  // LDI  r3,3
            PC_W'(7):  w_instr = 16'h7CFF;  // ADDI r3,0xFF
            PC_W'(8):  w_instr = 16'hBC0A;  // BEQZ r3,10
            PC_W'(9):  w_instr = 16'hA007;  // JMP  7
            PC_W'(10): w_instr = 16'hC000;  // HALT
            default:   w_instr = 16'h0000;
        endcase
    end

    assign w_op     = w_instr[15:12];
    assign w_rd     = w_instr[11:10];
    assign w_rs     = w_instr[9:8];
    assign w_imm    = w_instr[7:0];
    assign w_rd_val = r_regs[w_rd];
    assign w_rs_val = r_regs[w_rs];

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_ext      = '0;
        w_result   = '0;
        w_wr_en    = 1'b0;
        w_flag_upd = 1'b0;
        w_c_upd    = 1'b0;
        w_pc_next  = r_pc + PC_W'(1);
        case (w_op)
            OP_LDI: begin
                w_result = DATA_W'(w_imm);
                w_wr_en  = 1'b1;
            end
            OP_ADD, OP_ADDI: begin
                w_ext      = {1'b0, w_rd_val} + {1'b0, (w_op == OP_ADD) ? w_rs_val : DATA_W'(w_imm)};
                w_result   = w_ext[DATA_W-1:0];
                w_wr_en    = 1'b1;
                w_flag_upd = 1'b1;
                w_c_upd    = 1'b1;
            end
            OP_SUB: begin
                // The extra top bit of the difference is the borrow (rd < rs).
                w_ext      = {1'b0, w_rd_val} - {1'b0, w_rs_val};
                w_result   = w_ext[DATA_W-1:0];
                w_wr_en    = 1'b1;
                w_flag_upd = 1'b1;
                w_c_upd    = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR: begin
                w_result   = (w_op == OP_AND) ? (w_rd_val & w_rs_val) :
                             (w_op == OP_OR)  ? (w_rd_val | w_rs_val) : (w_rd_val ^ w_rs_val);
                w_wr_en    = 1'b1;
                w_flag_upd = 1'b1;
            end
            OP_LD: begin
                w_result = r_dmem[w_imm[3:0]];
                w_wr_en  = 1'b1;
            end
            OP_JMP:  w_pc_next = PC_W'(w_imm);
            OP_BEQZ: if (w_rd_val == '0) w_pc_next = PC_W'(w_imm);
            OP_HALT: w_pc_next = r_pc;
            default: ;
        endcase
    end

    // NOTE: the data memory is cleared by reset because a restart must see an all-zero memory.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_pc     <= '0;
            r_halted <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            for (int i = 0; i < 4; i++)  r_regs[i] <= '0;
            for (int i = 0; i < 16; i++) r_dmem[i] <= '0;
        end else if (!r_halted) begin
            // NOTE: non-blocking assignments so every read above sees pre-edge state.
            r_pc <= w_pc_next;
            if (w_wr_en)             r_regs[w_rd] <= w_result;
            if (w_op == OP_ST)       r_dmem[w_imm[3:0]] <= w_rd_val;
            if (w_flag_upd)          r_z <= (w_result == '0);
            if (w_c_upd)             r_c <= w_ext[DATA_W];
            if (w_op == OP_HALT)     r_halted <= 1'b1;
        end
    end

    assign pc_o      = r_pc;
    assign halted_o  = r_halted;
    assign wr_en_o   = w_wr_en & ~r_halted;
    assign wr_addr_o = w_rd;
    assign wr_data_o = w_result;

endmodule

// File: tb/tb_microprocesador.sv
// Directed bench for microprocesador: walks the fixed program edge by edge and
// checks writes, pc, flags and reset behaviour against hand-computed values.
module tb_microprocesador;

    logic       CLK;
    logic       Reset;
    logic [7:0] pc_o;
    logic       halted_o;
    logic       wr_en_o;
    logic [1:0] wr_addr_o;
    logic [7:0] wr_data_o;

    int n_cmp;
    int n_bad;

    // Expected pre-edge state for edges 1..16 after reset release.
    int exp_pc   [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 7, 8, 9, 7, 8, 10};
    int exp_en   [16] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int exp_addr [16] = '{0, 1, 0, 0, 2, 2, 3, 3, 0, 0, 3, 0, 0, 3, 0, 0};
    int exp_data [16] = '{5, 3, 8, 0, 8, 5, 3, 2, 0, 0, 1, 0, 0, 0, 0, 0};

    microprocesador #(.DATA_W(8), .PC_W(8)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .pc_o      (pc_o),
        .halted_o  (halted_o),
        .wr_en_o   (wr_en_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Checks the pre-edge write of each of the first n edges, then the state after it.
    task automatic run_edges(input int n);
        for (int k = 1; k <= n; k++) begin
            check($sformatf("pc_e%0d", k), pc_o, exp_pc[k-1]);
            check($sformatf("halt_e%0d", k), halted_o, 0);
            check($sformatf("wr_en_e%0d", k), wr_en_o, exp_en[k-1]);
            if (exp_en[k-1] == 1) begin
                check($sformatf("wr_addr_e%0d", k), wr_addr_o, exp_addr[k-1]);
                check($sformatf("wr_data_e%0d", k), wr_data_o, exp_data[k-1]);
            end
            @(posedge CLK);
            @(negedge CLK);
            case (k)
                1:  check("r0_5", dut.r_regs[0], 5);
                2:  check("r1_3", dut.r_regs[1], 3);
                3:  begin
                        check("r0_8", dut.r_regs[0], 8);
                        check("c_add", dut.r_c, 0);
                        check("z_add", dut.r_z, 0);
                    end
                4:  check("dmem2_8", dut.r_dmem[2], 8);
                5:  check("r2_ld", dut.r_regs[2], 8);
                6:  begin
                        check("r2_sub", dut.r_regs[2], 5);
                        check("c_sub", dut.r_c, 0);
                        check("z_sub", dut.r_z, 0);
                    end
                8:  begin
                        check("r3_2", dut.r_regs[3], 2);
                        check("c_addi1", dut.r_c, 1);
                        check("z_addi1", dut.r_z, 0);
                    end
                14: begin
                        check("r3_0", dut.r_regs[3], 0);
                        check("c_addi3", dut.r_c, 1);
                        check("z_addi3", dut.r_z, 1);
                    end
                16: begin
                        check("halted", halted_o, 1);
                        check("pc_halt", pc_o, 10);
                    end
                default: ;
            endcase
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Reset = 1'b1;

        #10 Reset = 1'b0;
        #1;
        check("rst_pc", pc_o, 0);
        check("rst_halt", halted_o, 0);
        for (int i = 0; i < 4; i++) check($sformatf("rst_r%0d", i), dut.r_regs[i], 0);
        #9 Reset = 1'b1;
        #1;
        run_edges(16);

        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            check("halt_wr_en", wr_en_o, 0);
            check("halt_pc", pc_o, 10);
        end

        // Reset from halt, held across a clock edge.
        @(negedge CLK);
        #2 Reset = 1'b0;
        #1;
        check("rh_pc", pc_o, 0);
        check("rh_halt", halted_o, 0);
        check("rh_r0", dut.r_regs[0], 0);
        check("rh_dmem2", dut.r_dmem[2], 0);
        check("rh_c", dut.r_c, 0);
        check("rh_z", dut.r_z, 0);
        @(posedge CLK);
        #1;
        check("rh_hold_pc", pc_o, 0);
        check("rh_hold_r0", dut.r_regs[0], 0);
        #2 Reset = 1'b1;
        @(negedge CLK);
        run_edges(11);

        // Asynchronous pulse mid-loop, between edges.
        #2 Reset = 1'b0;
        #1;
        check("rm_pc", pc_o, 0);
        check("rm_halt", halted_o, 0);
        check("rm_r3", dut.r_regs[3], 0);
        #1 Reset = 1'b1;
        run_edges(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/microprocesador.md
MICROPROCESADOR -- requirements
Module: microprocesador

Interface
REQ-001 Parameter DATA_W, default 8: datapath, register and data-memory word width; the fixed program and all values below assume 8.
REQ-002 Parameter PC_W, default 8: program counter width, giving a 256-word instruction ROM.
REQ-003 Port CLK  input  1: single system clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1: reset, asynchronous and active-low.
REQ-005 Port pc_o  output  PC_W: current program counter.
REQ-006 Port halted_o  output  1: high once HALT has executed.
REQ-007 Port wr_en_o  output  1: high in the cycle whose rising edge writes a register.
REQ-008 Port wr_addr_o  output  2: destination register of that write.
REQ-009 Port wr_data_o  output  DATA_W: data written by that write.

Function
REQ-010 Execution is single-cycle: each rising edge with Reset high and halted_o low executes the instruction ROM[pc] and updates pc.
REQ-011 Instruction format is 16 bits: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-012 State consists of four 8-bit registers r0..r3, 16x8 data memory, zero flag Z and carry flag C.
REQ-013 Opcodes (pc+1 unless stated otherwise):
- 0 NOP.
- 1 LDI: rd=imm.
- 2 ADD: rd=rd+rs.
- 3 SUB: rd=rd-rs.
- 4 AND: rd=rd&rs.
- 5 OR: rd=rd|rs.
- 6 XOR: rd=rd^rs.
- 7 ADDI: rd=rd+imm.
- 8 LD: rd=dmem[imm[3:0]].
- 9 ST: dmem[imm[3:0]]=rd.
- A JMP: pc=imm.
- B BEQZ: pc=imm if rd==0, else pc+1.
- C HALT: set halted.
- D-F: executed as NOP.
REQ-014 Arithmetic wraps modulo 256.
REQ-015 C is the carry-out of ADD/ADDI and is 1 on a SUB borrow (rd<rs); C is unchanged by all other opcodes.
REQ-016 Z=(result==0) after ADD/SUB/AND/OR/XOR/ADDI; Z is unchanged by all other opcodes.
REQ-017 wr_en_o/wr_addr_o/wr_data_o are combinational from the current instruction; wr_en_o=1 only for opcodes 1-8 while not halted.
REQ-018 Register-file reads see pre-edge values; ST and LD to the same address in consecutive cycles return the stored value.
REQ-019 pc wraps from 255 to 0.
REQ-020 Once halted, pc, registers, memory and flags hold and wr_en_o=0 until reset.
REQ-021 The instruction ROM is combinational and holds this fixed program; all other addresses are NOP:
- 0 LDI r0,5
- 1 LDI r1,3
- 2 ADD r0,r1
- 3 ST r0,[2]
- 4 LD r2,[2]
- 5 SUB r2,r1
- 6 LDI r3,3
- 7 ADDI r3,0xFF
- 8 BEQZ r3,10
- 9 JMP 7
- 10 HALT

Reset
REQ-022 Reset low immediately, independent of CLK, forces: pc=0, r0-r3=0, dmem=0, Z=0, C=0, halted_o=0.
REQ-023 While Reset is low, no state changes on clock edges; execution resumes from pc 0 at the first rising edge after Reset goes high.
REQ-024 Reset asserted mid-program, including after halt, restarts the program cleanly from address 0.

Verification
REQ-025 Reset low at t=10 ns, released at t=20 ns -> pc_o=0, halted_o=0 and registers 0 during reset; the first edge after release shows wr_en_o=1, wr_addr_o=0, wr_data_o=5.
REQ-026 Edges 1-3 after release -> writes r0=5, r1=3, then r0=8 with C=0, Z=0.
REQ-027 Edges 4-6 -> dmem[2]=8, then r2=8, then r2=5 (SUB), with C=0.
REQ-028 Loop -> r3 written 3, 2, 1, 0 (each ADDI sets C=1; the final one sets Z=1); BEQZ taken on edge 15; HALT on edge 16 -> halted_o=1, pc_o=10.
REQ-029 20 further edges after halt -> wr_en_o stays 0, pc_o stays 10.
REQ-030 Reset pulsed low asynchronously between clock edges mid-loop -> pc_o=0 and halted_o=0 immediately; after release the bench sees the same write sequence as REQ-026.
